// File: rtl/bp_pkg.sv
// Shared branch-predictor types: opcode constant, saturating counter helpers, clear/run FSM state.
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Counters are carried at the widest supported width; callers slice to CTR_W.
  localparam int unsigned CTR_W_MAX = 4;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } bp_state_e;

  function automatic ctr_t ctr_max(input int unsigned w);
    ctr_t m;
    m = '0;
    for (int i = 0; i < int'(CTR_W_MAX); i++) begin
      if (i < int'(w)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic ctr_t ctr_inc_sat(input ctr_t v, input int unsigned w);
    ctr_t m;
    m = ctr_max(w);
    return (v >= m) ? m : v + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec_sat(input ctr_t v);
    return (v == '0) ? '0 : v - ctr_t'(1);
  endfunction

endpackage

// File: rtl/sat_ctr_table.sv
// Counter table: async read port, one sync write port muxed between clear fill and saturating update.
module sat_ctr_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 12,
  parameter int unsigned CTR_W    = 2,
  parameter logic [CTR_W-1:0] INIT_CTR = '1
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] mem [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] wr_data;
  logic [CTR_W-1:0] upd_cur;
  ctr_t             upd_cur_ext;
  ctr_t             upd_new_ext;
  logic             unused_hi;

  assign rd_ctr  = mem[rd_idx];
  assign upd_cur = mem[upd_idx];

  always_comb begin
    upd_cur_ext = '0;
    upd_cur_ext[CTR_W-1:0] = upd_cur;
    upd_new_ext = upd_taken ? ctr_inc_sat(upd_cur_ext, CTR_W)
                            : ctr_dec_sat(upd_cur_ext);
  end

  generate
    if (CTR_W < CTR_W_MAX) begin : g_hi
      assign unused_hi = ^upd_new_ext[CTR_W_MAX-1:CTR_W];
    end else begin : g_no_hi
      assign unused_hi = 1'b0;
    end
  endgenerate

  // Clear wins the write port; the FSM never asserts both, but the priority is explicit.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = upd_new_ext[CTR_W-1:0];
    if (clr_en) begin
      wr_en   = 1'b1;
      wr_idx  = clr_idx;
      wr_data = INIT_CTR;
    end else if (upd_en) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// Gshare/bimodal pattern history table: clear FSM, global history and index hash around sat_ctr_table.
// Define GSHARE_PHT_HIST_EN for gshare indexing; leave it undefined for a pure bimodal predictor.
module gshare_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 12,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned GHR_W    = 12,
  parameter logic [CTR_W-1:0] INIT_CTR = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             ready
);

  bp_state_e        state_reg;
  logic [IDX_W-1:0] clr_ptr_reg;
  logic             ready_reg;

  logic             clr_en;
  logic             upd_en;
  logic [IDX_W-1:0] pc_idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             unused_pc;

  assign pc_idx    = fetch_pc[IDX_W+1:2];
  assign unused_pc = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

  // An edge with rst high must not touch the table or history, whatever the state.
  assign clr_en = (state_reg == CLEAR) && !rst;
  assign upd_en = (state_reg == RUN) && upd_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == {IDX_W{1'b1}}) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg   <= CLEAR;
          clr_ptr_reg <= '0;
          ready_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef GSHARE_PHT_HIST_EN
  logic [GHR_W-1:0] ghr_reg;
  logic [GHR_W-1:0] ghr_next;
  logic [IDX_W-1:0] ghr_ext;

  // Non-speculative history: shifted only when a branch resolves in RUN.
  assign ghr_next = GHR_W'({ghr_reg, upd_taken});
  assign ghr_ext  = IDX_W'(ghr_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (upd_en) begin
      ghr_reg <= ghr_next;
    end
  end

  assign pred_idx = pc_idx ^ ghr_ext;
`else
  assign pred_idx = pc_idx;
`endif

  sat_ctr_table #(
    .IDX_W    (IDX_W),
    .CTR_W    (CTR_W),
    .INIT_CTR (INIT_CTR)
  ) u_table (
    .clk       (clk),
    .rd_idx    (pred_idx),
    .rd_ctr    (rd_ctr),
    .clr_en    (clr_en),
    .clr_idx   (clr_ptr_reg),
    .upd_en    (upd_en),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken)
  );

  assign pred_taken = ready_reg ? rd_ctr[CTR_W-1] : INIT_CTR[CTR_W-1];
  assign ready      = ready_reg;

endmodule
